// File: rtl/escalonador_processos_pkg.sv
// Shared types and helpers for the round-robin process scheduler.
package escalonador_processos_pkg;

  typedef enum logic [2:0] {
    SO        = 3'd0,
    SELECIONA = 3'd1,
    RESTAURA  = 3'd2,
    EXEC      = 3'd3,
    SALVA     = 3'd4,
    FIM       = 3'd5
  } estado_t;

  // Process id reserved for the operating system.
  localparam int unsigned ID_SO = 0;

  // Bits needed to hold ids 0..n (0 = OS).
  function automatic int unsigned id_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  // Bits needed to index n process slots (at least one).
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/escalonador_processos_seletor_rr.sv
// Circular priority picker: first set bit of mask strictly after ptr, wrapping
// around so that ptr itself is considered last.
module escalonador_processos_seletor_rr
  import escalonador_processos_pkg::*;
#(
  parameter int unsigned N_PROC = 4
) (
  input  logic [N_PROC-1:0]              mask,
  input  logic [ptr_width(N_PROC)-1:0]   ptr,
  output logic [ptr_width(N_PROC)-1:0]   pick,
  output logic                           none
);

  localparam int unsigned PTR_W = ptr_width(N_PROC);

  int unsigned idx;

  // Scan the N slots starting just after ptr; keep the first live one.
  always_comb begin
    pick = '0;
    none = 1'b1;
    idx  = 0;
    for (int i = 0; i < int'(N_PROC); i++) begin
      idx = (32'(ptr) + 32'(i) + 32'd1) % N_PROC;
      if (none && mask[PTR_W'(idx)]) begin
        pick = PTR_W'(idx);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/escalonador_processos.sv
// Round-robin process scheduler: tracks the running process, preempts on
// quantum expiry, retires processes on HALT, drives context save/restore and
// the partition base address.
module escalonador_processos
  import escalonador_processos_pkg::*;
#(
  parameter int unsigned N_PROC       = 4,
  parameter int unsigned QUANTUM      = 16,
  parameter int unsigned TAM_PARTICAO = 50,
  parameter int unsigned BASE_SO      = 50,
  parameter int unsigned ENDER_W      = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          step,
  input  logic                          WAIT,
  input  logic                          HALT,
  input  logic                          carrega,
  input  logic [N_PROC-1:0]             proc_valido,
  output logic [id_width(N_PROC)-1:0]   id_proc,
  output logic                          Sel_BIOS,
  output logic [ENDER_W-1:0]            base_ender,
  output logic                          salva_ctx,
  output logic                          restaura_ctx,
  output logic                          quantum_over,
  output logic [N_PROC-1:0]             ativos,
  output logic                          todos_fim
);

  localparam int unsigned ID_W  = id_width(N_PROC);
  localparam int unsigned PTR_W = ptr_width(N_PROC);
  localparam int unsigned CNT_W = $clog2(QUANTUM);

  if (BASE_SO + N_PROC * TAM_PARTICAO > (1 << ENDER_W)) begin : g_cfg_err
    $error("escalonador_processos: process partitions exceed the address space");
  end

  estado_t            state, next_state;
  logic [PTR_W-1:0]   ptr, ptr_d;
  logic [CNT_W-1:0]   counter, counter_d;
  logic [ID_W-1:0]    id_d;
  logic [N_PROC-1:0]  ativos_d, cur_bit;
  logic               sel_d, salva_d, restaura_d, qo_d, fim_d;
  logic [PTR_W-1:0]   pick;
  logic               none;
  logic               expira, outros;

  escalonador_processos_seletor_rr #(.N_PROC(N_PROC)) u_seletor (
    .mask (ativos),
    .ptr  (ptr),
    .pick (pick),
    .none (none)
  );

  // Slot of the running process and slice-expiry conditions.
  always_comb begin
    cur_bit = N_PROC'(1) << ptr;
    outros  = |(ativos & ~cur_bit);
    expira  = step && !WAIT && !HALT && (counter == CNT_W'(QUANTUM - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= SO;
    else       state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      SO, FIM: begin
        if (carrega) next_state = (proc_valido == '0) ? FIM : SELECIONA;
      end
      SELECIONA: next_state = none ? FIM : RESTAURA;
      RESTAURA:  next_state = EXEC;
      EXEC: begin
        if (step && HALT)         next_state = outros ? SELECIONA : FIM;
        else if (expira && outros) next_state = SALVA;
      end
      SALVA:     next_state = SELECIONA;
      default:   next_state = SO;
    endcase
  end

  // Next values of the datapath registers and registered outputs.
  always_comb begin
    id_d       = id_proc;
    ptr_d      = ptr;
    ativos_d   = ativos;
    counter_d  = counter;
    qo_d       = 1'b0;
    case (state)
      SO, FIM: begin
        if (carrega) begin
          ativos_d = proc_valido;
          ptr_d    = PTR_W'(N_PROC - 1);
        end
      end
      SELECIONA: begin
        if (!none) begin
          id_d  = ID_W'(pick) + ID_W'(1);
          ptr_d = pick;
        end
      end
      RESTAURA: counter_d = '0;
      EXEC: begin
        if (step && HALT) begin
          ativos_d = ativos & ~cur_bit;
        end else if (step && !WAIT) begin
          if (expira) begin
            counter_d = '0;
            qo_d      = 1'b1;
          end else begin
            counter_d = counter + CNT_W'(1);
          end
        end
      end
      default: ;
    endcase
    if (next_state == FIM || next_state == SO) id_d = ID_W'(ID_SO);
    sel_d      = (next_state != EXEC);
    salva_d    = (next_state == SALVA);
    restaura_d = (next_state == RESTAURA);
    fim_d      = (next_state == FIM);
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_proc      <= ID_W'(ID_SO);
      ptr          <= '0;
      ativos       <= '0;
      counter      <= '0;
      Sel_BIOS     <= 1'b1;
      salva_ctx    <= 1'b0;
      restaura_ctx <= 1'b0;
      quantum_over <= 1'b0;
      todos_fim    <= 1'b0;
    end else begin
      id_proc      <= id_d;
      ptr          <= ptr_d;
      ativos       <= ativos_d;
      counter      <= counter_d;
      Sel_BIOS     <= sel_d;
      salva_ctx    <= salva_d;
      restaura_ctx <= restaura_d;
      quantum_over <= qo_d;
      todos_fim    <= fim_d;
    end
  end

  // Partition base of the current id; the OS sits at address 0.
  always_comb begin
    if (id_proc == ID_W'(ID_SO)) base_ender = '0;
    else base_ender = ENDER_W'(BASE_SO)
                    + (ENDER_W'(id_proc) - ENDER_W'(1)) * ENDER_W'(TAM_PARTICAO);
  end

endmodule

// File: tb/tb_escalonador_processos.sv
// Scoreboard bench for escalonador_processos: directed scenarios push expected
// restore/save/expiry ids; a negedge monitor pops and checks them.
module tb_escalonador_processos;

  localparam int N_PROC  = 4;
  localparam int QUANTUM = 16;
  localparam int ID_W    = 3;
  localparam int ENDER_W = 9;

  logic               clk = 1'b0;
  logic               reset, step, wait_s, halt_s, carrega;
  logic [N_PROC-1:0]  proc_valido;
  logic [ID_W-1:0]    id_proc;
  logic               sel_bios, salva_ctx, restaura_ctx, quantum_over, todos_fim;
  logic [ENDER_W-1:0] base_ender;
  logic [N_PROC-1:0]  ativos;

  int checks = 0;
  int errors = 0;
  int n_rest = 0, n_salva = 0, n_qo = 0, step_cnt = 0;
  int q_rest[$], q_salva[$], q_qo[$];
  int e_m;

  escalonador_processos #(
    .N_PROC(N_PROC), .QUANTUM(QUANTUM), .TAM_PARTICAO(50), .BASE_SO(50), .ENDER_W(ENDER_W)
  ) dut (
    .clk(clk), .reset(reset), .step(step), .WAIT(wait_s), .HALT(halt_s),
    .carrega(carrega), .proc_valido(proc_valido), .id_proc(id_proc),
    .Sel_BIOS(sel_bios), .base_ender(base_ender), .salva_ctx(salva_ctx),
    .restaura_ctx(restaura_ctx), .quantum_over(quantum_over), .ativos(ativos),
    .todos_fim(todos_fim)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: pop expected ids on each pulse, count effective steps per slice.
  always @(negedge clk) begin
    if (restaura_ctx) begin
      n_rest++;
      if (q_rest.size() == 0) check("restore_unexpected", int'(id_proc), -1);
      else begin
        e_m = q_rest.pop_front();
        check("restore_id", int'(id_proc), e_m);
        check("restore_base", int'(base_ender), (e_m == 0) ? 0 : 50 + (e_m - 1) * 50);
      end
      step_cnt = 0;
    end
    if (salva_ctx) begin
      n_salva++;
      check("save_with_expiry", int'(quantum_over), 1);
      if (q_salva.size() == 0) check("save_unexpected", int'(id_proc), -1);
      else begin
        e_m = q_salva.pop_front();
        check("save_id", int'(id_proc), e_m);
      end
    end
    if (quantum_over) begin
      n_qo++;
      if (q_qo.size() == 0) check("expiry_unexpected", int'(id_proc), -1);
      else begin
        e_m = q_qo.pop_front();
        check("expiry_id", int'(id_proc), e_m);
      end
      check("slice_steps", step_cnt, QUANTUM);
      step_cnt = 0;
    end
    if (reset) step_cnt = 0;
    else if (!sel_bios && step && !wait_s && !halt_s) step_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the selected event counter reaches target (0=restore 1=save 2=expiry).
  task automatic wait_evt(input int kind, input int target);
    int budget;
    int cnt;
    budget = 0;
    cnt = (kind == 0) ? n_rest : (kind == 1) ? n_salva : n_qo;
    while (cnt < target && budget < 3000) begin
      tick();
      budget++;
      cnt = (kind == 0) ? n_rest : (kind == 1) ? n_salva : n_qo;
    end
    if (cnt < target) check("timeout_wait_event", cnt, target);
  endtask

  task automatic pulse_carrega(input logic [N_PROC-1:0] m);
    carrega = 1'b1;
    proc_valido = m;
    tick();
    carrega = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_id"}, int'(id_proc), 0);
    check({tag, "_sel_bios"}, int'(sel_bios), 1);
    check({tag, "_ativos"}, int'(ativos), 0);
    check({tag, "_pulses"}, int'({salva_ctx, restaura_ctx, quantum_over}), 0);
    check({tag, "_todos_fim"}, int'(todos_fim), 0);
  endtask

  int seq_rest[8]  = '{1, 2, 4, 1, 2, 4, 1, 2};
  int seq_salva[7] = '{1, 2, 4, 1, 2, 4, 1};
  int c;

  initial begin
    reset = 1'b1; step = 1'b0; wait_s = 1'b0; halt_s = 1'b0;
    carrega = 1'b0; proc_valido = '0;
    tick(); tick();
    check_reset_state("reset_initial");
    check("base_id0", int'(base_ender), 0);
    reset = 1'b0;
    step = 1'b1;

    // Round robin over mask 1011, then HALT id 2 mid-slice.
    foreach (seq_rest[i]) q_rest.push_back(seq_rest[i]);
    foreach (seq_salva[i]) begin
      q_salva.push_back(seq_salva[i]);
      q_qo.push_back(seq_salva[i]);
    end
    pulse_carrega(4'b1011);
    wait_evt(0, 8);
    repeat (4) tick();
    q_rest.push_back(4);
    halt_s = 1'b1; tick(); halt_s = 1'b0;
    wait_evt(0, 9);
    check("ativos_after_halt2", int'(ativos), 4'b1001);

    // HALT id 4; id 1 then runs alone with bare expiry pulses.
    repeat (3) tick();
    q_rest.push_back(1);
    halt_s = 1'b1; tick(); halt_s = 1'b0;
    wait_evt(0, 10);
    check("ativos_after_halt4", int'(ativos), 4'b0001);
    repeat (3) q_qo.push_back(1);
    wait_evt(2, 9);
    c = 0;
    while (!quantum_over && c < 100) begin tick(); c++; end
    check("solo_third_expiry_seen", int'(quantum_over), 1);

    // HALT on the last step of the slice: retirement wins, no expiry.
    for (int j = 0; j < QUANTUM; j++) begin
      halt_s = (j == QUANTUM - 1);
      tick();
    end
    halt_s = 1'b0;
    check("halt_at_expiry_qo", int'(quantum_over), 0);
    check("halt_at_expiry_fim", int'(todos_fim), 1);
    check("halt_at_expiry_id", int'(id_proc), 0);
    check("halt_at_expiry_sel", int'(sel_bios), 1);
    check("halt_at_expiry_ativos", int'(ativos), 0);

    // WAIT freezes the slice for 10 cycles.
    q_rest.push_back(2); q_salva.push_back(2); q_qo.push_back(2);
    wait_s = 1'b1;
    pulse_carrega(4'b0110);
    wait_evt(0, 11);
    repeat (10) tick();
    wait_s = 1'b0;
    c = 0;
    while (!quantum_over && c < 100) begin tick(); c++; end
    check("wait_slice_len", c, QUANTUM);
    check("wait_in_salva", int'(salva_ctx), 1);

    // Reset while in SALVA.
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_state("reset_in_salva");

    // Reset while in EXEC; id 1 base address.
    q_rest.push_back(1);
    pulse_carrega(4'b0001);
    wait_evt(0, 12);
    check("base_id1", int'(base_ender), 50);
    check("exec_sel_bios", int'(sel_bios), 0);
    repeat (3) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_reset_state("reset_in_exec");

    // id 3 base address, then an empty mask goes straight to FIM.
    q_rest.push_back(3);
    pulse_carrega(4'b0100);
    wait_evt(0, 13);
    check("id3", int'(id_proc), 3);
    check("base_id3", int'(base_ender), 150);
    reset = 1'b1; tick(); reset = 1'b0;
    pulse_carrega(4'b0000);
    check("empty_mask_fim", int'(todos_fim), 1);
    check("empty_mask_id", int'(id_proc), 0);
    check("empty_mask_sel", int'(sel_bios), 1);
    repeat (5) tick();

    check("left_restore", q_rest.size(), 0);
    check("left_save", q_salva.size(), 0);
    check("left_expiry", q_qo.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
